// File: rtl/nano_vw_loader.sv
// nano_vw_loader: receives a console byte stream (high byte, then low byte
// of each word) and replays every word onto the bootrom console vw bus with
// setup / strobe / release timing on the write flag.
//
// Byte handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1. in_valid may rise or fall at any time. A byte offered
// while in_ready is 0 stays with the producer until it is taken.
module nano_vw_loader #(
    parameter int SETUP_CYCLES = 2,   // legal 1..15
    parameter int HOLD_CYCLES  = 4    // legal 3..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  base_addr,
    input  logic [7:0]  word_count,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        abort,
    output logic [31:0] vw_console_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  words_written,
    output logic [15:0] checksum,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_HI  = 3'd1,
        GET_LO  = 3'd2,
        SETUP   = 3'd3,
        STROBE  = 3'd4,
        RELEASE = 3'd5,
        FINISH  = 3'd6
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0] MAX_WORDS  = 8'd128;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [6:0]  r_addr;
    logic [7:0]  r_remaining;
    logic [7:0]  r_hi;
    logic [6:0]  r_vw_addr;
    logic [15:0] r_vw_data;
    logic        r_flag;
    logic        r_abort;
    logic [7:0]  r_words;
    logic [15:0] r_sum;

    logic        w_xfer;
    logic        w_start_ok;
    logic        w_release_end;
    logic        w_strobe_entry;

    // Handshake and status outputs decoded from the registered state.
    // A latched abort closes in_ready so no byte is swallowed on the way out.
    always_comb begin
        in_ready = ((r_state == GET_HI) || (r_state == GET_LO)) && !r_abort;
        busy     = (r_state != IDLE);
        done     = (r_state == FINISH);
    end

    assign w_xfer          = in_valid && in_ready;
    assign w_start_ok      = (r_state == IDLE) && start;
    assign w_release_end   = (r_state == RELEASE) && (r_cnt == HOLD_LAST);
    assign w_strobe_entry  = (r_state == SETUP) && (w_next == STROBE);

    assign vw_console_data = {7'b0, r_flag, 1'b0, r_vw_addr, r_vw_data};
    assign words_written   = r_words;
    assign checksum        = r_sum;
    assign o_dbg_state     = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (word_count == 8'd0) ? FINISH : GET_HI;
                end
            end
            GET_HI: begin
                if (r_abort) begin
                    w_next = FINISH;
                end else if (w_xfer) begin
                    w_next = GET_LO;
                end
            end
            GET_LO: begin
                if (r_abort) begin
                    w_next = FINISH;
                end else if (w_xfer) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_next = STROBE;
                end
            end
            STROBE: begin
                if (r_cnt == HOLD_LAST) begin
                    w_next = RELEASE;
                end
            end
            RELEASE: begin
                if (r_cnt == HOLD_LAST) begin
                    // Abort raised in the very last release clock still counts.
                    if ((r_remaining == 8'd1) || r_abort || abort) begin
                        w_next = FINISH;
                    end else begin
                        w_next = GET_HI;
                    end
                end
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Phase timer: restarts on every state change, counts in timed phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 4'd0;
        end else if ((r_state == SETUP) || (r_state == STROBE) ||
                     (r_state == RELEASE)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Abort latch: armed in any busy state, dropped when the load ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_abort <= 1'b0;
        end else if (r_state == FINISH) begin
            r_abort <= 1'b0;
        end else if ((r_state != IDLE) && abort) begin
            r_abort <= 1'b1;
        end
    end

    // Load datapath: address/count bookkeeping, byte assembly, vw word
    // register, write flag and the per-load statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= 7'd0;
            r_remaining <= 8'd0;
            r_hi        <= 8'd0;
            r_vw_addr   <= 7'd0;
            r_vw_data   <= 16'd0;
            r_flag      <= 1'b0;
            r_words     <= 8'd0;
            r_sum       <= 16'd0;
        end else begin
            if (w_start_ok) begin
                r_addr      <= base_addr;
                // Counts above 128 are clipped so a load never exceeds
                // the 128-rise limit of the console.
                r_remaining <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                r_words     <= 8'd0;
                r_sum       <= 16'd0;
            end
            if ((r_state == GET_HI) && w_xfer) begin
                r_hi <= in_data;
            end
            // Address and data are frozen here until the word is released.
            if ((r_state == GET_LO) && w_xfer) begin
                r_vw_addr <= r_addr;
                r_vw_data <= {r_hi, in_data};
            end
            if (w_strobe_entry) begin
                r_words <= r_words + 8'd1;
                r_sum   <= r_sum + r_vw_data;
            end
            if (w_release_end) begin
                r_addr      <= r_addr + 7'd1;
                r_remaining <= r_remaining - 8'd1;
            end
            r_flag <= (w_next == STROBE);
        end
    end

endmodule

// File: doc/nano_vw_loader.md
NANO_VW_LOADER -- requirements
Module: nano_vw_loader

Interface
REQ-001 Parameter SETUP_CYCLES, default 2, clocks vw address/data are stable before the write flag rises (legal range 1..15).
REQ-002 Parameter HOLD_CYCLES, default 4, clocks the write flag stays high, then stays low, per word (legal range 3..15).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  7  first word address of the load; captured on an accepted start.
REQ-007 word_count  input  8  number of 16-bit words to load; captured on an accepted start; legal range 0..128.
REQ-008 in_data  input  8  console byte stream, high byte first then low byte of each word.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  loader accepts in_data; a byte transfers on any edge where in_valid and in_ready are both 1.
REQ-011 abort  input  1  request to stop the load at the next word boundary.
REQ-012 vw_console_data  output  32  bootrom console word: [31:25] 0, [24] write flag, [23] 0, [22:16] word address, [15:0] word data.
REQ-013 busy  output  1  high from an accepted start until return to IDLE.
REQ-014 done  output  1  one-cycle pulse when a load completes or is aborted.
REQ-015 words_written  output  8  count of write-flag rising edges issued in the current or last load.
REQ-016 checksum  output  16  modulo-2^16 sum of the data words issued in the current or last load.

Function
REQ-017 The FSM SHALL have the states IDLE, GET_HI, GET_LO, SETUP, STROBE, RELEASE and FINISH.
REQ-018 IDLE, start=1, word_count!=0: capture base_addr and word_count, clear words_written and checksum, busy=1, go to GET_HI.
REQ-019 IDLE, start=1, word_count=0: clear the counters, go to FINISH; no write flag is issued.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 in_ready SHALL be 1 only in GET_HI and GET_LO.
REQ-022 GET_HI transfer: store the high byte, go to GET_LO.
REQ-023 GET_LO transfer: register address and data into vw_console_data[22:16]/[15:0] with the flag still 0, go to SETUP.
REQ-024 SETUP SHALL last SETUP_CYCLES clocks, then go to STROBE with the flag driven to 1.
REQ-025 STROBE SHALL last HOLD_CYCLES clocks; on entry, words_written increments and checksum adds the word.
REQ-026 RELEASE SHALL drive the flag to 0 for HOLD_CYCLES clocks.
REQ-027 At the end of RELEASE, the address SHALL increment modulo 128 (127 wraps to 0) and the remaining count SHALL decrement.
REQ-028 After RELEASE, the FSM SHALL go to FINISH when the remaining count is 0 or abort was seen; otherwise it SHALL go to GET_HI.
REQ-029 Address and data bits SHALL stay constant from the GET_LO transfer until the end of RELEASE.
REQ-030 Flag timing: the flag is 0 for at least SETUP_CYCLES clocks before each rise, and there are at most 128 rises per load.
REQ-031 abort SHALL be latched in any busy state.
REQ-032 A latched abort in GET_HI or GET_LO SHALL go to FINISH without issuing the pending word, and the partially received bytes SHALL be discarded.
REQ-033 A latched abort in SETUP, STROBE or RELEASE SHALL take effect only after the current word has completed.
REQ-034 FINISH SHALL last one clock with done=1, then go to IDLE with busy=0 and the latched abort cleared.
REQ-035 words_written and checksum SHALL hold their values in IDLE until the next accepted start.
REQ-036 Bytes offered while in_ready=0 SHALL be neither consumed nor lost.

Reset
REQ-037 rst=1 SHALL force IDLE on the next edge regardless of state, including mid-STROBE.
REQ-038 On reset, vw_console_data SHALL be 0 (write flag low), and in_ready, busy and done SHALL be 0.
REQ-039 On reset, words_written, checksum and the latched abort SHALL be 0.
REQ-040 A partial word received before reset SHALL be discarded and SHALL NOT generate a write.

Verification
REQ-041 Single word: start with base_addr=5, word_count=1, then bytes 0x12, 0x34 -> one flag rise with vw_console_data=0x01051234, SETUP=2 and HOLD=4 clocks; done pulses; words_written=1; checksum=0x1234.
REQ-042 Wrap: base_addr=126, word_count=3, words 0x0001/0x0002/0x0003 -> addresses 126, 127, 0; checksum=0x0006; words_written=3.
REQ-043 Backpressure and gaps: in_valid toggled randomly during a 128-word load -> exactly 128 rises; each word at the correct address; no byte dropped or duplicated.
REQ-044 Abort: abort asserted during STROBE of word 2 of 10 -> word 2 completes, no further rises, done=1, words_written=2; abort during GET_LO of word 3 -> word 3 is not written.
REQ-045 Reset in STROBE: rst asserted -> flag 0 on the next edge, all outputs 0, and a subsequent start loads normally.
REQ-046 Zero count and busy start: word_count=0 -> done after 2 clocks with no rise; start while busy -> ignored and the base address is unchanged.
